// File: rtl/keyled_pio_pkg.sv
// Shared register map, edge-select encodings and a constant clog2 helper for the
// key/switch input PIO.
package keyled_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Smallest n with 2**n >= value; clog2(1) is 0.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/keyled_debounce_bit.sv
// One input channel: 2-flop synchroniser followed by a consecutive-stable-cycle
// debounce counter that only accepts a new level after DB_CYCLES agreeing samples.
module keyled_debounce_bit
    import keyled_pio_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 50000,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic raw,
    output logic stable
);

    logic sync1;
    logic sync2;

    // NOTE: every flop in this design is written with <= so that all registers
    // sample the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    assign raw = sync2;

    generate
        if (DB_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable <= IDLE_LEVEL;
                end else begin
                    stable <= sync2;
                end
            end
        end else begin : g_count
            localparam int               CNT_W    = clog2(DB_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

            logic [CNT_W-1:0] cnt;

            // Any sample that agrees with the accepted level restarts the count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt    <= '0;
                    stable <= IDLE_LEVEL;
                end else if (sync2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/keyled_pio_key_db.sv
// Avalon-MM input PIO for the DE2 keys/switches: per-bit debounce, configurable
// edge capture with write-1-to-clear, per-bit irq mask and a registered level irq.
module keyled_pio_key_db
    import keyled_pio_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DB_CYCLES  = 50000,
    parameter int unsigned EDGE_TYPE  = 0,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clear;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic             bus_write;
    logic [31:0]      read_mux;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            keyled_debounce_bit #(
                .DB_CYCLES  (DB_CYCLES),
                .IDLE_LEVEL (IDLE_LEVEL)
            ) u_db (
                .clk    (clk),
                .reset  (reset),
                .din    (in_port[i]),
                .raw    (raw[i]),
                .stable (stable[i])
            );
        end

        if (WIDTH < 32) begin : g_unused
            logic unused_writedata;
            assign unused_writedata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign bus_write  = chipselect & ~write_n;
    assign edge_clear = (bus_write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_det = ~stable & stable_d;
            EDGE_ANY:  edge_det = stable ^ stable_d;
            default:   edge_det = stable & ~stable_d;
        endcase
    end

    // NOTE: read_mux gets its full default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA: read_mux[WIDTH-1:0] = stable;
            ADDR_RAW:  read_mux[WIDTH-1:0] = raw;
            ADDR_MASK: read_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: read_mux[WIDTH-1:0] = edge_capture;
        endcase
    end

    // A new edge is OR-ed in after the clear, so a coincident clear never hides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d     <= {WIDTH{IDLE_LEVEL}};
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            stable_d     <= stable;
            edge_capture <= (edge_capture & ~edge_clear) | edge_det;
            if (bus_write && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            readdata     <= read_mux;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule

// File: tb/tb_keyled_pio_key_db.sv
// Bench for keyled_pio_key_db: two instances (debounced falling-edge, bypassed any-edge)
// compared every cycle against a sample-window model, plus directed literal checks.
module tb_keyled_pio_key_db;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        irq_a;
    logic        irq_b;
    logic        chk_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    keyled_pio_key_db #(
        .WIDTH(4), .DB_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rdata_a), .irq(irq_a)
    );

    keyled_pio_key_db #(
        .WIDTH(4), .DB_CYCLES(0), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rdata_b), .irq(irq_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  stable;
        logic [3:0]  stable_d;
        logic [3:0]  raw;
        logic [3:0]  mask;
        logic [3:0]  ecap;
        logic [31:0] rdata;
        logic        irq;
    } mst_t;

    mst_t       ma;
    mst_t       mb;
    logic [3:0] sh_a [0:7];
    logic [3:0] sh_b [0:7];

    function automatic mst_t mst_reset();
        mst_t s;
        s.stable   = 4'hF;
        s.stable_d = 4'hF;
        s.raw      = 4'hF;
        s.mask     = 4'h0;
        s.ecap     = 4'h0;
        s.rdata    = 32'h0;
        s.irq      = 1'b0;
        return s;
    endfunction

    // smp[m] is the in_port value sampled m edges ago (smp[0] = this edge).
    // A level is accepted once it filled the last db synchronised samples.
    function automatic mst_t model_step(input mst_t s, input logic [3:0] smp [0:7],
                                        input int db, input int etype, input logic wr_en,
                                        input logic [1:0] addr, input logic [31:0] wd);
        mst_t       n;
        logic [3:0] det;
        logic [3:0] clr;
        logic       all_same;
        n     = s;
        n.raw = smp[1];
        if (db == 0) begin
            n.stable = smp[2];
        end else begin
            for (int i = 0; i < 4; i++) begin
                all_same = 1'b1;
                for (int m = 2; m <= db + 1; m++)
                    if (smp[m][i] !== smp[2][i]) all_same = 1'b0;
                if (all_same) n.stable[i] = smp[2][i];
            end
        end
        case (etype)
            0:       det = s.stable & ~s.stable_d;
            1:       det = ~s.stable & s.stable_d;
            default: det = s.stable ^ s.stable_d;
        endcase
        clr        = (wr_en && addr == 2'd3) ? wd[3:0] : 4'h0;
        n.ecap     = (s.ecap & ~clr) | det;
        n.stable_d = s.stable;
        if (wr_en && addr == 2'd2) n.mask = wd[3:0];
        case (addr)
            2'd0:    n.rdata = {28'h0, s.stable};
            2'd1:    n.rdata = {28'h0, s.raw};
            2'd2:    n.rdata = {28'h0, s.mask};
            default: n.rdata = {28'h0, s.ecap};
        endcase
        n.irq = |(s.ecap & s.mask);
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ma = mst_reset();
            mb = mst_reset();
            for (int j = 0; j < 8; j++) begin
                sh_a[j] = 4'hF;
                sh_b[j] = 4'hF;
            end
        end else begin
            for (int j = 7; j > 0; j--) begin
                sh_a[j] = sh_a[j-1];
                sh_b[j] = sh_b[j-1];
            end
            sh_a[0] = in_a;
            sh_b[0] = in_b;
            ma = model_step(ma, sh_a, 4, 1, chipselect & ~write_n, address, writedata);
            mb = model_step(mb, sh_b, 0, 2, chipselect & ~write_n, address, writedata);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a_readdata", rdata_a, ma.rdata);
            check("model_a_irq", {31'h0, irq_a}, {31'h0, ma.irq});
            check("model_b_readdata", rdata_b, mb.rdata);
            check("model_b_irq", {31'h0, irq_b}, {31'h0, mb.irq});
        end
    end

    // ---------------- bus helpers ----------------
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] ra, output logic [31:0] rb);
        address = a;
        @(negedge clk);
        ra = rdata_a;
        rb = rdata_b;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        in_a       = 4'hF;
        in_b       = 4'hF;
        chk_en     = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        in_b   = 4'h7;

        // Reset values
        rd(2'd0, ra, rb); check("reset_data", ra, 32'hF);
        rd(2'd1, ra, rb); check("reset_raw", ra, 32'hF);
        rd(2'd2, ra, rb); check("reset_mask", ra, 32'h0);
        rd(2'd3, ra, rb); check("reset_edge", ra, 32'h0);
        check("reset_irq", {31'h0, irq_a}, 32'h0);

        // Debounce latency: change sampled at edge t lands in stable at t+5
        in_a    = 4'hE;
        address = 2'd0;
        repeat (6) @(negedge clk);
        check("db_not_early", rdata_a, 32'hF);
        @(negedge clk);
        check("db_on_time", rdata_a, 32'hE);

        // Glitch rejection, then a held falling edge on bit 1
        wr(2'd3, 32'hF);
        in_a = 4'hC;
        repeat (3) @(negedge clk);
        in_a = 4'hE;
        repeat (12) @(negedge clk);
        rd(2'd0, ra, rb); check("glitch_data", ra, 32'hE);
        rd(2'd3, ra, rb); check("glitch_edge", ra, 32'h0);
        in_a = 4'hC;
        repeat (10) @(negedge clk);
        rd(2'd3, ra, rb); check("held_edge", ra, 32'h2);
        rd(2'd0, ra, rb); check("held_data", ra, 32'hC);

        // Mask and irq
        wr(2'd3, 32'hF);
        in_a = 4'hE;
        repeat (10) @(negedge clk);
        wr(2'd2, 32'h2);
        in_a = 4'h8;
        repeat (10) @(negedge clk);
        rd(2'd3, ra, rb); check("mask_edge", ra, 32'h6);
        check("mask_irq_on", {31'h0, irq_a}, 32'h1);
        wr(2'd3, 32'h2);
        check("irq_still_on", {31'h0, irq_a}, 32'h1);
        @(negedge clk);
        check("irq_off", {31'h0, irq_a}, 32'h0);
        rd(2'd3, ra, rb); check("partial_clear", ra, 32'h4);

        // Set/clear collision on bit 0
        wr(2'd3, 32'hF);
        in_a = 4'h9;
        repeat (10) @(negedge clk);
        in_a = 4'h8;
        repeat (6) @(negedge clk);
        wr(2'd3, 32'h1);
        rd(2'd3, ra, rb); check("collision_set_wins", ra, 32'h1);
        wr(2'd3, 32'h1);
        rd(2'd3, ra, rb); check("collision_second_clear", ra, 32'h0);

        // Any-edge, no debounce, on dut_b bit 3
        wr(2'd3, 32'hF);
        rd(2'd3, ra, rb); check("b_cleared", rb, 32'h0);
        in_b = 4'hF;
        repeat (5) @(negedge clk);
        rd(2'd3, ra, rb); check("b_rise_capture", rb, 32'h8);
        wr(2'd3, 32'h8);
        rd(2'd3, ra, rb); check("b_rise_cleared", rb, 32'h0);
        in_b = 4'h7;
        repeat (5) @(negedge clk);
        rd(2'd3, ra, rb); check("b_fall_capture", rb, 32'h8);
        wr(2'd3, 32'h8);
        rd(2'd3, ra, rb); check("b_fall_cleared", rb, 32'h0);

        // Randomised traffic, including glitches and occasional mid-debounce resets
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 11) == 0) in_a[i] = ~in_a[i];
                if ($urandom_range(0, 3) == 0)  in_b[i] = ~in_b[i];
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 1) == 1);
            write_n    = ($urandom_range(0, 9) >= 3);
            writedata  = $urandom;
            reset      = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
